// File: rtl/spi_pkg.sv
// Shared types for the SPI slave: frame FSM states.
package spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    // Bit counter must hold the value SIZE itself (saturation marker).
    function automatic int unsigned spi_cnt_width(input int unsigned size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI serial bus pins: the master drives clock, select and data; the slave drives miso.
interface spi_slave_if;

    logic sclk_in;
    logic cs_n_in;
    logic mosi_in;
    logic miso_out;

    modport master (
        output sclk_in,
        output cs_n_in,
        output mosi_in,
        input  miso_out
    );

    modport slave (
        input  sclk_in,
        input  cs_n_in,
        input  mosi_in,
        output miso_out
    );

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Edges are suppressed until every flop holds a real sample, so reset values
// never masquerade as an edge.
module sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic [STAGES:0]   primed_q;

    // Synchronizer chain, edge-history flop and primed tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {STAGES{RESET_VAL}};
            prev_q   <= RESET_VAL;
            primed_q <= '0;
        end else begin
            sync_q   <= {sync_q[STAGES-2:0], din};
            prev_q   <= sync_q[STAGES-1];
            primed_q <= {primed_q[STAGES-1:0], 1'b1};
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = primed_q[STAGES] &  sync_q[STAGES-1] & ~prev_q;
    assign fall = primed_q[STAGES] & ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, oversampled by internal_clk (>= 4x sclk).
// Receives a SIZE-bit word per frame and shifts out the buffered tx word.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SIZE        = 40,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            internal_clk,
    input  logic            reset_n_in,
    spi_slave_if.slave      spi,
    input  logic [SIZE-1:0] tx_data_in,
    input  logic            tx_load_in,
    output logic [SIZE-1:0] rx_data_out,
    output logic            rx_valid_out,
    input  logic            rx_ack_in,
    output logic            overrun_out,
    output logic            frame_error_out,
    output logic            busy_out
);

    localparam int unsigned    CW      = spi_cnt_width(SIZE);
    localparam logic [CW-1:0]  CNT_MAX = CW'(SIZE);

    logic sclk_rise, sclk_fall, sclk_lvl;
    logic cs_rise, cs_fall, cs_lvl;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk   (internal_clk),
        .rst_n (reset_n_in),
        .din   (spi.sclk_in),
        .dout  (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk   (internal_clk),
        .rst_n (reset_n_in),
        .din   (spi.cs_n_in),
        .dout  (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk   (internal_clk),
        .rst_n (reset_n_in),
        .din   (spi.mosi_in),
        .dout  (mosi_s),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // Only edges of sclk/cs_n and the level of mosi matter.
    assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

    spi_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SIZE-1:0] shift_q, shift_d;
    logic [SIZE-1:0] tx_buf_q;
    logic [SIZE-1:0] rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            miso_q, miso_d;
    logic            complete_q, complete_d;

    // Frame FSM state, counter, shift register and serial output.
    always_ff @(posedge internal_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            miso_q      <= 1'b0;
            frame_err_q <= 1'b0;
            complete_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            miso_q      <= miso_d;
            frame_err_q <= frame_err_d;
            complete_q  <= complete_d;
        end
    end

    // Next-state logic: start on cs_n fall, shift on sclk edges, stop on cs_n rise.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        miso_d      = miso_q;
        frame_err_d = 1'b0;
        complete_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d = SHIFT;
                    shift_d = tx_buf_q;
                    cnt_d   = '0;
                    miso_d  = tx_buf_q[SIZE-1];
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    // A partial frame is an error; an empty one is not.
                    if (cnt_q != '0 && cnt_q < CNT_MAX) begin
                        frame_err_d = 1'b1;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    miso_d = 1'b0;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[SIZE-2:0], mosi_s};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CNT_MAX - CW'(1)) begin
                        complete_d = 1'b1;
                        miso_d     = 1'b0;
                    end
                end else if (sclk_fall) begin
                    miso_d = shift_q[SIZE-1];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transmit buffer: loadable at any time, used at the next frame start.
    always_ff @(posedge internal_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            tx_buf_q <= '0;
        end else if (tx_load_in) begin
            tx_buf_q <= tx_data_in;
        end
    end

    // Receive word register, valid flag and overrun flag.
    always_ff @(posedge internal_clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    // Completion wins over ack; ack in the same cycle suppresses overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        if (complete_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            if (rx_ack_in) begin
                overrun_d = 1'b0;
            end else if (rx_valid_q) begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack_in) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    assign spi.miso_out    = miso_q;
    assign rx_data_out     = rx_data_q;
    assign rx_valid_out    = rx_valid_q;
    assign overrun_out     = overrun_q;
    assign frame_error_out = frame_err_q;
    assign busy_out        = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bench-driven SPI master plus a frame-level model.
module tb_spi_slave;

    localparam int SIZE = 40;
    localparam int HP   = 50;  // sclk half period, 10x slower than internal_clk

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [SIZE-1:0] tx_data = '0;
    logic            tx_load = 1'b0;
    logic [SIZE-1:0] rx_data;
    logic            rx_valid;
    logic            rx_ack = 1'b0;
    logic            overrun;
    logic            frame_error;
    logic            busy;

    spi_slave_if bus ();

    always #5 clk = ~clk;

    spi_slave #(.SIZE(SIZE), .SYNC_STAGES(2)) dut (
        .internal_clk    (clk),
        .reset_n_in      (rst_n),
        .spi             (bus),
        .tx_data_in      (tx_data),
        .tx_load_in      (tx_load),
        .rx_data_out     (rx_data),
        .rx_valid_out    (rx_valid),
        .rx_ack_in       (rx_ack),
        .overrun_out     (overrun),
        .frame_error_out (frame_error),
        .busy_out        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model state.
    logic [SIZE-1:0] m_tx = '0;
    logic [SIZE-1:0] m_rx = '0;
    bit              m_valid = 0;
    bit              m_ovr = 0;
    int              m_fe = 0;
    bit              settled = 0;

    int fe_cycles = 0;
    int fe_pulses = 0;
    bit fe_prev = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Between transactions the DUT must match the model every cycle.
    always @(negedge clk) begin
        if (settled) begin
            check("idle_rx_data", 64'(rx_data), 64'(m_rx));
            check("idle_rx_valid", 64'(rx_valid), 64'(m_valid));
            check("idle_overrun", 64'(overrun), 64'(m_ovr));
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_miso", 64'(bus.miso_out), 64'(0));
        end
    end

    // Frame-error pulse monitor.
    always @(negedge clk) begin
        if (frame_error) fe_cycles <= fe_cycles + 1;
        if (frame_error && !fe_prev) fe_pulses <= fe_pulses + 1;
        fe_prev <= frame_error;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [SIZE-1:0] w);
        @(posedge clk); #1;
        tx_data = w;
        tx_load = 1'b1;
        @(posedge clk); #1;
        tx_load = 1'b0;
        m_tx = w;
    endtask

    task automatic ack();
        settled = 0;
        @(posedge clk); #1;
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
        if (m_valid) begin
            m_valid = 0;
            m_ovr = 0;
        end
        repeat (2) @(posedge clk);
        settled = 1;
    endtask

    task automatic reset_mid();
        @(negedge clk);
        rst_n = 1'b0;
        bus.sclk_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_data", 64'(rx_data), 64'(0));
        check("rst_rx_valid", 64'(rx_valid), 64'(0));
        check("rst_overrun", 64'(overrun), 64'(0));
        check("rst_frame_error", 64'(frame_error), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_miso", 64'(bus.miso_out), 64'(0));
        m_tx = '0;
        m_rx = '0;
        m_valid = 0;
        m_ovr = 0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        // cs_n still low: no frame may start without a fresh falling edge.
        #1 check("post_rst_busy", 64'(busy), 64'(0));
        settled = 1;
    endtask

    // Run one frame of nbits sclk pulses; pat holds the mosi bits, MSB sent first.
    task automatic frame(input logic [63:0] pat, input int nbits, input int load_at,
                         input logic [SIZE-1:0] load_word, input int rst_at,
                         output logic [SIZE-1:0] miso_word);
        logic [SIZE-1:0] cur;
        logic            b;
        logic            exp_b;
        settled = 0;
        cur = m_tx;
        miso_word = '0;
        bus.cs_n_in = 1'b0;
        #(2 * HP);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset_mid();
                return;
            end
            if (i == load_at) load(load_word);
            bus.mosi_in = pat[nbits-1-i];
            #(HP);
            b = bus.miso_out;
            exp_b = 1'b0;
            if (i < SIZE) begin
                exp_b = cur[SIZE-1-i];
                miso_word[SIZE-1-i] = b;
            end
            check("frame_busy", 64'(busy), 64'(1));
            check("miso_bit", 64'(b), 64'(exp_b));
            bus.sclk_in = 1'b1;
            #(HP);
            bus.sclk_in = 1'b0;
        end
        #(HP);
        bus.cs_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        repeat (10) @(posedge clk);
        if (nbits >= SIZE) begin
            if (m_valid) m_ovr = 1;
            m_rx = SIZE'(pat >> (nbits - SIZE));
            m_valid = 1;
        end else if (nbits > 0) begin
            m_fe++;
        end
        settled = 1;
    endtask

    logic [SIZE-1:0] w;
    int fe0;
    int fc0;

    initial begin
        bus.sclk_in = 1'b0;
        bus.cs_n_in = 1'b1;
        bus.mosi_in = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_rx_data", 64'(rx_data), 64'(0));
        check("reset_rx_valid", 64'(rx_valid), 64'(0));
        check("reset_overrun", 64'(overrun), 64'(0));
        check("reset_frame_error", 64'(frame_error), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_miso", 64'(bus.miso_out), 64'(0));
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        settled = 1;

        // Basic 40-bit frame.
        load(40'hA55AC33CF0);
        frame(64'h123456789A, 40, -1, '0, -1, w);
        check("t1_miso_word", 64'(w), 64'h00A55AC33CF0);
        check("t1_rx_data", 64'(rx_data), 64'h00123456789A);
        check("t1_rx_valid", 64'(rx_valid), 64'(1));

        // Second frame without ack: overrun, tx word resent.
        frame(64'hFFFFFFFFFF, 40, -1, '0, -1, w);
        check("t2_miso_word", 64'(w), 64'h00A55AC33CF0);
        check("t2_rx_data", 64'(rx_data), 64'h00FFFFFFFFFF);
        check("t2_overrun", 64'(overrun), 64'(1));
        ack();
        check("t2_ack_valid", 64'(rx_valid), 64'(0));
        check("t2_ack_overrun", 64'(overrun), 64'(0));

        // Aborted after 17 bits: one single-cycle error pulse.
        fe0 = fe_pulses;
        fc0 = fe_cycles;
        frame(64'h1ABCD, 17, -1, '0, -1, w);
        check("t3_fe_pulses", 64'(fe_pulses - fe0), 64'(1));
        check("t3_fe_cycles", 64'(fe_cycles - fc0), 64'(1));
        check("t3_rx_valid", 64'(rx_valid), 64'(0));
        check("t3_busy", 64'(busy), 64'(0));

        // Select with no clocks: not an error.
        fe0 = fe_pulses;
        frame(64'h0, 0, -1, '0, -1, w);
        check("t3b_no_fe", 64'(fe_pulses - fe0), 64'(0));

        // 45 pulses: first 40 captured, extra bits ignored, miso 0 afterwards.
        frame(64'({40'h0F1E2D3C4B, 5'b10111}), 45, -1, '0, -1, w);
        check("t4_rx_data", 64'(rx_data), 64'h000F1E2D3C4B);
        check("t4_miso_word", 64'(w), 64'h00A55AC33CF0);
        ack();

        // Load during a frame affects only the next frame.
        frame(64'h5A5A5A5A5A, 40, 10, 40'h0000000001, -1, w);
        check("t5_old_word", 64'(w), 64'h00A55AC33CF0);
        ack();
        frame(64'h0102030405, 40, -1, '0, -1, w);
        check("t5_new_word", 64'(w), 64'h000000000001);
        check("t5_rx_data", 64'(rx_data), 64'h000102030405);
        ack();

        // Reset at bit 20, then a clean frame.
        fe0 = fe_pulses;
        frame(64'hDEADBEEF00, 40, -1, '0, 20, w);
        settled = 0;
        bus.cs_n_in = 1'b1;
        repeat (10) @(posedge clk);
        settled = 1;
        check("t6_no_fe", 64'(fe_pulses - fe0), 64'(0));
        frame(64'hCAFEBABE12, 40, -1, '0, -1, w);
        check("t6_miso_word", 64'(w), 64'h000000000000);
        check("t6_rx_data", 64'(rx_data), 64'h00CAFEBABE12);
        check("t6_rx_valid", 64'(rx_valid), 64'(1));

        // Whole-run error pulse bookkeeping.
        check("fe_total_model", 64'(m_fe), 64'(1));
        check("fe_total_pulses", 64'(fe_pulses), 64'(m_fe));
        check("fe_total_cycles", 64'(fe_cycles), 64'(m_fe));

        settled = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SIZE, default 40: frame length in bits, minimum 2.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flops per input synchronizer, minimum 2.
REQ-003 SHALL have port internal_clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n_in, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port sclk_in, input, 1 bit: SPI clock from the master, asynchronous.
REQ-006 SHALL have port cs_n_in, input, 1 bit: chip select, active-low, asynchronous.
REQ-007 SHALL have port mosi_in, input, 1 bit: serial data from the master.
REQ-008 SHALL have port miso_out, output, 1 bit: serial data to the master.
REQ-009 SHALL have port tx_data_in, input, SIZE bits: word for the next frame.
REQ-010 SHALL have port tx_load_in, input, 1 bit: one-cycle strobe that captures tx_data_in.
REQ-011 SHALL have port rx_data_out, output, SIZE bits: last completely received word.
REQ-012 SHALL have port rx_valid_out, output, 1 bit: rx_data_out holds an unread word.
REQ-013 SHALL have port rx_ack_in, input, 1 bit: consumer acknowledges rx_data_out.
REQ-014 SHALL have port overrun_out, output, 1 bit: a frame completed while rx_valid_out was 1.
REQ-015 SHALL have port frame_error_out, output, 1 bit: one-cycle pulse when cs_n_in rises mid-frame.
REQ-016 SHALL have port busy_out, output, 1 bit: 1 while state is SHIFT.

Function
REQ-017 SHALL pass sclk_in, cs_n_in and mosi_in through SYNC_STAGES-flop synchronizers, then through rising/falling edge detectors on the synchronized sclk and cs_n.
REQ-018 SHALL operate correctly only when the internal_clk frequency is at least 4x the sclk_in frequency; slower internal_clk gives undefined behaviour.
REQ-019 SHALL implement SPI mode 0, MSB first: sample mosi on the synchronized sclk rising edge; advance miso on the synchronized sclk falling edge.
REQ-020 SHALL use a two-state FSM, IDLE and SHIFT.
REQ-021 SHALL transition IDLE->SHIFT on a synchronized cs_n falling edge and, in that same cycle:
  - load the shift register from the tx buffer;
  - clear the bit counter;
  - drive miso_out with the tx buffer MSB.
REQ-022 SHALL, on each sclk rising edge in SHIFT with bit counter < SIZE, shift mosi into the LSB and increment the counter; counter width is $clog2(SIZE)+1.
REQ-023 SHALL, on each sclk falling edge in SHIFT with counter < SIZE, drive miso_out with the next bit of the shift register.
REQ-024 SHALL, when the counter reaches SIZE, do the following in the cycle after the SIZE-th rising edge:
  - copy the shift register to rx_data_out;
  - set rx_valid_out to 1.
REQ-025 SHALL ignore sclk edges while the counter equals SIZE (saturate) and drive miso_out to 0 in that condition.
REQ-026 SHALL transition SHIFT->IDLE on a synchronized cs_n rising edge.
REQ-027 SHALL, if that cs_n rising edge occurs with counter in 1..SIZE-1, pulse frame_error_out for one cycle and leave rx_data_out, rx_valid_out and overrun_out unchanged.
REQ-028 SHALL treat a cs_n rising edge with counter 0 as no error.
REQ-029 SHALL drive miso_out to 0 in IDLE.
REQ-030 SHALL, on tx_load_in=1, capture tx_data_in into the tx buffer in any state; a load during SHIFT affects only the next frame.
REQ-031 SHALL retain the tx buffer across frames when no load occurs (the last loaded word is resent).
REQ-032 SHALL clear rx_valid_out on rx_ack_in=1; rx_ack_in with rx_valid_out=0 has no effect.
REQ-033 SHALL resolve a frame completing in the same cycle as rx_ack_in as follows:
  - the new word is stored;
  - rx_valid_out stays 1;
  - no overrun is flagged.
REQ-034 SHALL, when a frame completes while rx_valid_out=1 without ack, overwrite rx_data_out and set overrun_out; overrun_out stays set until the next rx_ack_in.

Reset
REQ-035 SHALL, while reset_n_in=0, asynchronously force the following:
  - state IDLE, counter 0, shift register 0;
  - tx buffer 0, rx_data_out 0;
  - rx_valid_out 0, overrun_out 0, frame_error_out 0, busy_out 0, miso_out 0;
  - synchronizer cs_n stages 1, sclk stages 0.
REQ-036 SHALL, when reset asserts mid-frame, discard the partial word without a frame_error pulse.
REQ-037 SHALL, after reset release with cs_n_in already low, not start a frame until a cs_n falling edge is seen.

Structure
REQ-038 SHALL take its state enum (IDLE, SHIFT) from shared package spi_pkg.
REQ-039 SHALL use one sub-module, sync_edge: parameterized synchronizer with rise/fall outputs, instantiated for sclk and cs_n; mosi uses its synchronized output only.

Verification
REQ-040 SHALL cover: load 0xA55AC33CF0, run a 40-bit frame with MOSI=0x123456789A -> miso bits equal 0xA55AC33CF0 MSB first; rx_data_out=0x123456789A; rx_valid_out=1.
REQ-041 SHALL cover: two frames with no ack, second MOSI=0xFFFFFFFFFF -> rx_data_out=0xFFFFFFFFFF; overrun_out=1; ack clears both flags.
REQ-042 SHALL cover: cs_n raised after 17 bits -> frame_error_out pulses exactly 1 cycle; rx_valid_out stays 0; busy_out=0.
REQ-043 SHALL cover: 45 sclk pulses within one CS -> only the first 40 bits captured; miso_out=0 for pulses 41-45.
REQ-044 SHALL cover: tx_load_in of 0x0000000001 during a frame -> current frame sends the old word; next frame sends 0x0000000001.
REQ-045 SHALL cover: reset_n_in pulsed low at bit 20 -> all outputs 0; next full frame received correctly.
